t_ff_count_ctrl: RTL

- Sequencer for a WIDTH-bit bank of toggle flip-flops.
- Computes the per-bit toggle vector each cycle, so the bank behaves as a programmable modulo up/down counter.
- Supports start/stop, pause, synchronous clear/load and one-shot completion.
- Sits between the timer/control logic and the toggle-flop storage. Storage state is observable only through count.

---
 rtl/t_ff_count_ctrl_pkg.sv | 22 ++
 rtl/t_ff_cell.sv | 21 ++
 rtl/t_ff_count_ctrl.sv | 131 +++++++++++++
 3 files changed

// File: rtl/t_ff_count_ctrl_pkg.sv
// Shared encodings for the toggle-flop counter sequencer.
package t_ff_count_ctrl_pkg;

    // Controller states. The encoding is fixed so external debug tools can decode it.
    typedef enum logic [1:0] {
        ST_IDLE = 2'b00,
        ST_RUN  = 2'b01,
        ST_DONE = 2'b10
    } state_t;

    // Source selected by the toggle-vector priority mux, highest priority first.
    typedef enum logic [2:0] {
        SRC_ZERO    = 3'd0,  // no toggles (idle, done, paused, stopping)
        SRC_CLEAR   = 3'd1,  // t = count           -> count becomes 0
        SRC_LOAD    = 3'd2,  // t = count ^ load_val -> count becomes load_val
        SRC_WRAP_UP = 3'd3,  // t = count           -> wrap to 0
        SRC_INC     = 3'd4,  // ripple-carry increment pattern
        SRC_WRAP_DN = 3'd5,  // t = limit (count is 0) -> wrap to limit
        SRC_DEC     = 3'd6   // ripple-borrow decrement pattern
    } tsel_t;

endpackage

// File: rtl/t_ff_cell.sv
// Single toggle flip-flop: q flips on each rising edge where t is high.
module t_ff_cell (
    input  logic clk,
    input  logic rst,
    input  logic t,
    output logic q,
    output logic q_bar
);

    // Toggle storage with asynchronous active-low clear.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            q <= 1'b0;
        end else begin
            q <= q ^ t;
        end
    end

    assign q_bar = ~q;

endmodule

// File: rtl/t_ff_count_ctrl.sv
// Sequencer that drives a bank of toggle flops as a programmable modulo
// up/down counter with start/stop, pause, clear/load and one-shot completion.
//
// Handshake note: start, stop, clear and load are single-cycle command pulses
// sampled on the rising edge; there is no ready/acknowledge. pause, up_dn and
// one_shot are levels sampled every cycle. Every command takes effect on the
// next rising edge; there is no combinational path from inputs to count.
module t_ff_count_ctrl
    import t_ff_count_ctrl_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             stop,
    input  logic             pause,
    input  logic             up_dn,
    input  logic             one_shot,
    input  logic             clear,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic [WIDTH-1:0] limit,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             running,
    output logic             done,
    output state_t           dbg_state
);

    state_t           state_q;
    state_t           state_d;
    tsel_t            tsel;
    logic [WIDTH-1:0] t;
    logic [WIDTH-1:0] count_n;
    logic             wrap;
    logic             carry;

    assign dbg_state = state_q;

    // Priority select for the toggle source.
    always_comb begin
        tsel = SRC_ZERO;
        if (clear) begin
            tsel = SRC_CLEAR;
        end else if (load) begin
            tsel = SRC_LOAD;
        end else if (state_q == ST_RUN && !stop && !pause) begin
            if (up_dn) begin
                tsel = (count >= limit) ? SRC_WRAP_UP : SRC_INC;
            end else begin
                tsel = (count == '0) ? SRC_WRAP_DN : SRC_DEC;
            end
        end
    end

    // Build the toggle vector; increment/decrement use a running carry/borrow.
    // The borrow chain reads the flops' q_bar outputs (all-ones below bit i).
    always_comb begin
        t     = '0;
        carry = 1'b1;
        case (tsel)
            SRC_CLEAR:   t = count;
            SRC_LOAD:    t = count ^ load_val;
            SRC_WRAP_UP: t = count;
            SRC_WRAP_DN: t = limit;
            SRC_INC: begin
                for (int i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & count[i];
                end
            end
            SRC_DEC: begin
                for (int i = 0; i < WIDTH; i++) begin
                    t[i]  = carry;
                    carry = carry & count_n[i];
                end
            end
            default: t = '0;
        endcase
    end

    assign wrap = (tsel == SRC_WRAP_UP) || (tsel == SRC_WRAP_DN);

    // Next-state logic; clear/load own the cycle and leave the state alone.
    always_comb begin
        state_d = state_q;
        if (!clear && !load) begin
            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (start) state_d = ST_RUN;
                end
                ST_RUN: begin
                    if (stop) begin
                        state_d = ST_IDLE;
                    end else if (wrap && one_shot) begin
                        state_d = ST_DONE;
                    end
                end
                default: state_d = ST_IDLE;
            endcase
        end
    end

    // State register plus registered tc pulse and status flags.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q <= ST_IDLE;
            tc      <= 1'b0;
            running <= 1'b0;
            done    <= 1'b0;
        end else begin
            state_q <= state_d;
            tc      <= wrap;
            running <= (state_d == ST_RUN);
            done    <= (state_d == ST_DONE);
        end
    end

    // Toggle-flop storage bank.
    for (genvar i = 0; i < WIDTH; i++) begin : g_bank
        t_ff_cell u_cell (
            .clk   (clk),
            .rst   (rst),
            .t     (t[i]),
            .q     (count[i]),
            .q_bar (count_n[i])
        );
    end

endmodule
